// File: rtl/mod_counter_updown.sv
// mod_counter_updown
// Modulo-N up/down counter with parallel load, enable and cascade outputs.
// CARRY_OUT / BORROW_OUT are combinational so a chain of stages advances on
// the same clock edge: stage n+1 Enable = stage n CARRY_OUT | BORROW_OUT.

module mod_counter_updown #(
   parameter int WIDTH    = 6,
   parameter int MAX      = 59,
   parameter int RST_VAL  = 0,
   parameter int SATURATE = 0
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             Enable,
   input  logic             LD,
   input  logic [WIDTH-1:0] IN,
   input  logic             Up,
   input  logic             Down,
   output logic [WIDTH-1:0] COUNT,
   output logic             CARRY_OUT,
   output logic             BORROW_OUT,
   output logic             LD_ERR
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
   localparam logic             SAT   = (SATURATE != 0);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             ld_err_reg;
   logic             ld_err_next;

   logic at_max;
   logic at_zero;
   logic do_load;
   logic do_up;
   logic do_down;
   logic load_over;

   // Decode the request for this edge; load outranks counting, Up&Down cancels.
   always_comb begin
      at_max    = (count_reg == MAX_V);
      at_zero   = (count_reg == '0);
      do_load   = Enable & LD;
      do_up     = Enable & ~LD & Up & ~Down;
      do_down   = Enable & ~LD & Down & ~Up;
      load_over = (IN > MAX_V);
   end

   // Next count: compare against the limits before stepping so the
   // arithmetic never overflows WIDTH bits.
   always_comb begin
      count_next  = count_reg;
      ld_err_next = 1'b0;
      if (do_load) begin
         if (load_over) begin
            count_next  = MAX_V;
            ld_err_next = 1'b1;
         end else begin
            count_next = IN;
         end
      end else if (do_up) begin
         if (!at_max) begin
            count_next = count_reg + 1'b1;
         end else if (!SAT) begin
            count_next = '0;
         end
      end else if (do_down) begin
         if (!at_zero) begin
            count_next = count_reg - 1'b1;
         end else if (!SAT) begin
            count_next = MAX_V;
         end
      end
   end

   // Cascade strobes: flag this cycle's wrap so the next stage steps on the same edge.
   always_comb begin
      CARRY_OUT  = ~Clr & do_up   & at_max  & ~SAT;
      BORROW_OUT = ~Clr & do_down & at_zero & ~SAT;
   end

   // State register; Clr discards any pending load or wrap.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         count_reg  <= RST_V;
         ld_err_reg <= 1'b0;
      end else begin
         count_reg  <= count_next;
         ld_err_reg <= ld_err_next;
      end
   end

   assign COUNT  = count_reg;
   assign LD_ERR = ld_err_reg;

endmodule

// File: tb/tb_mod_counter_updown.sv
// Testbench for mod_counter_updown: directed table, hand sequences for wrap,
// saturation and cascade, and randomized traffic against an arithmetic model.

module tb_mod_counter_updown;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   // main instance: WIDTH 6, MAX 59, wrapping
   logic       m_clr, m_en, m_ld, m_up, m_down;
   logic [5:0] m_in;
   logic [5:0] m_cnt;
   logic       m_cy, m_bw, m_err;

   // saturating instance: WIDTH 5, MAX 23
   logic       s_clr, s_en, s_ld, s_up, s_down;
   logic [4:0] s_in;
   logic [4:0] s_cnt;
   logic       s_cy, s_bw, s_err;

   // cascade hh:mm:ss
   logic       c_clr, c_en, c_ld, c_up;
   logic [5:0] c_sec_in, c_min_in;
   logic [4:0] c_hr_in;
   logic [5:0] sec_cnt, min_cnt;
   logic [4:0] hr_cnt;
   logic       sec_cy, sec_bw, sec_err, min_cy, min_bw, min_err, hr_cy, hr_bw, hr_err;
   logic       min_en, hr_en;

   // one-bit instance
   logic       w_clr, w_en, w_ld, w_up, w_down;
   logic [0:0] w_in;
   logic [0:0] w_cnt;
   logic       w_cy, w_bw, w_err;

   assign min_en = c_ld | sec_cy | sec_bw;
   assign hr_en  = c_ld | min_cy | min_bw;

   mod_counter_updown #(.WIDTH(6), .MAX(59), .RST_VAL(0), .SATURATE(0)) dut (
      .Clk(clk), .Clr(m_clr), .Enable(m_en), .LD(m_ld), .IN(m_in), .Up(m_up), .Down(m_down),
      .COUNT(m_cnt), .CARRY_OUT(m_cy), .BORROW_OUT(m_bw), .LD_ERR(m_err));

   mod_counter_updown #(.WIDTH(5), .MAX(23), .RST_VAL(0), .SATURATE(1)) u_sat (
      .Clk(clk), .Clr(s_clr), .Enable(s_en), .LD(s_ld), .IN(s_in), .Up(s_up), .Down(s_down),
      .COUNT(s_cnt), .CARRY_OUT(s_cy), .BORROW_OUT(s_bw), .LD_ERR(s_err));

   mod_counter_updown #(.WIDTH(6), .MAX(59)) u_sec (
      .Clk(clk), .Clr(c_clr), .Enable(c_en), .LD(c_ld), .IN(c_sec_in), .Up(c_up), .Down(1'b0),
      .COUNT(sec_cnt), .CARRY_OUT(sec_cy), .BORROW_OUT(sec_bw), .LD_ERR(sec_err));

   mod_counter_updown #(.WIDTH(6), .MAX(59)) u_min (
      .Clk(clk), .Clr(c_clr), .Enable(min_en), .LD(c_ld), .IN(c_min_in), .Up(c_up), .Down(1'b0),
      .COUNT(min_cnt), .CARRY_OUT(min_cy), .BORROW_OUT(min_bw), .LD_ERR(min_err));

   mod_counter_updown #(.WIDTH(5), .MAX(23)) u_hr (
      .Clk(clk), .Clr(c_clr), .Enable(hr_en), .LD(c_ld), .IN(c_hr_in), .Up(c_up), .Down(1'b0),
      .COUNT(hr_cnt), .CARRY_OUT(hr_cy), .BORROW_OUT(hr_bw), .LD_ERR(hr_err));

   mod_counter_updown #(.WIDTH(1), .MAX(1)) u_w1 (
      .Clk(clk), .Clr(w_clr), .Enable(w_en), .LD(w_ld), .IN(w_in), .Up(w_up), .Down(w_down),
      .COUNT(w_cnt), .CARRY_OUT(w_cy), .BORROW_OUT(w_bw), .LD_ERR(w_err));

   typedef struct {
      bit clr; bit en; bit ld; int din; bit up; bit down;
      int exp_cnt; bit exp_cy; bit exp_bw; bit exp_err;
   } vec_t;

   vec_t tbl[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Behavioural model: range 0..max, modulo arithmetic or clamping.
   function automatic void ref_next(input int max, input int sat, input int cur,
                                    input int clr, input int en, input int ld, input int din,
                                    input int up, input int down,
                                    output int nxt, output int err, output int cy, output int bw);
      nxt = cur; err = 0; cy = 0; bw = 0;
      if (clr != 0) begin
         nxt = 0;
      end else if (en != 0 && ld != 0) begin
         if (din > max) begin nxt = max; err = 1; end
         else nxt = din;
      end else if (en != 0 && up != 0 && down == 0) begin
         if (sat != 0) nxt = (cur < max) ? cur + 1 : max;
         else begin nxt = (cur + 1) % (max + 1); cy = (cur == max) ? 1 : 0; end
      end else if (en != 0 && down != 0 && up == 0) begin
         if (sat != 0) nxt = (cur > 0) ? cur - 1 : 0;
         else begin nxt = (cur + max) % (max + 1); bw = (cur == 0) ? 1 : 0; end
      end
   endfunction

   initial begin
      int m_model, s_model;
      int nx, ne, ncy, nbw;
      int sx, se, scy, sbw;

      //            clr en ld din up dn  cnt cy bw err
      tbl[0]  = '{0, 1, 1, 45, 0, 0, 45, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 63, 0, 0, 59, 0, 0, 1};
      tbl[2]  = '{0, 0, 0,  0, 0, 0, 59, 0, 0, 0};
      tbl[3]  = '{0, 1, 1, 10, 1, 0, 10, 0, 0, 0};
      tbl[4]  = '{0, 0, 1, 30, 1, 0, 10, 0, 0, 0};
      tbl[5]  = '{0, 1, 0,  0, 1, 1, 10, 0, 0, 0};
      tbl[6]  = '{0, 1, 1,  0, 0, 0,  0, 0, 0, 0};
      tbl[7]  = '{0, 1, 0,  0, 0, 1, 59, 0, 1, 0};
      tbl[8]  = '{0, 1, 0,  0, 1, 1, 59, 0, 0, 0};
      tbl[9]  = '{0, 1, 0,  0, 1, 0,  0, 1, 0, 0};
      tbl[10] = '{0, 1, 1, 63, 0, 0, 59, 0, 0, 1};
      tbl[11] = '{1, 1, 1, 45, 1, 0,  0, 0, 0, 0};
      tbl[12] = '{0, 1, 1, 63, 0, 0, 59, 0, 0, 1};
      tbl[13] = '{0, 1, 1, 63, 0, 0, 59, 0, 0, 1};
      tbl[14] = '{0, 1, 1,  5, 0, 0,  5, 0, 0, 0};
      tbl[15] = '{0, 1, 0,  0, 0, 1,  4, 0, 0, 0};
      tbl[16] = '{0, 1, 1, 63, 0, 0, 59, 0, 0, 1};
      tbl[17] = '{0, 0, 1, 63, 0, 0, 59, 0, 0, 0};
      tbl[18] = '{0, 1, 0,  0, 1, 0,  0, 1, 0, 0};
      tbl[19] = '{1, 1, 0,  0, 1, 0,  0, 0, 0, 0};

      m_clr = 1; m_en = 1; m_ld = 0; m_in = '0; m_up = 1; m_down = 0;
      s_clr = 1; s_en = 0; s_ld = 0; s_in = '0; s_up = 0; s_down = 0;
      c_clr = 1; c_en = 0; c_ld = 0; c_up = 0; c_sec_in = '0; c_min_in = '0; c_hr_in = '0;
      w_clr = 1; w_en = 0; w_ld = 0; w_in = '0; w_up = 0; w_down = 0;

      // reset held for two edges with Up and Enable active
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_carry", 32'(m_cy), 0);
         @(posedge clk); #1;
         chk("reset_count", 32'(m_cnt), 0);
         chk("reset_lderr", 32'(m_err), 0);
         $display("reset %0d: count=%0d ld_err=%0d", i, m_cnt, m_err);
      end
      chk("reset_sat", 32'(s_cnt), 0);
      chk("reset_sec", 32'(sec_cnt), 0);
      chk("reset_w1", 32'(w_cnt), 0);

      // free-running up count through one full wrap
      m_clr = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         chk("up_carry", 32'(m_cy), (i == 60) ? 1 : 0);
         @(posedge clk); #1;
         chk("up_count", 32'(m_cnt), i % 60);
         $display("up %0d: count=%0d", i, m_cnt);
      end

      // directed table
      for (int r = 0; r < 20; r++) begin
         m_clr = tbl[r].clr; m_en = tbl[r].en; m_ld = tbl[r].ld; m_in = 6'(tbl[r].din);
         m_up = tbl[r].up; m_down = tbl[r].down;
         @(negedge clk);
         chk("tbl_carry", 32'(m_cy), 32'(tbl[r].exp_cy));
         chk("tbl_borrow", 32'(m_bw), 32'(tbl[r].exp_bw));
         @(posedge clk); #1;
         chk("tbl_count", 32'(m_cnt), 32'(tbl[r].exp_cnt));
         chk("tbl_lderr", 32'(m_err), 32'(tbl[r].exp_err));
         $display("row %0d: count=%0d ld_err=%0d", r, m_cnt, m_err);
      end
      m_clr = 0; m_en = 0; m_ld = 0; m_up = 0; m_down = 0;

      // saturating instance: hold at both limits
      s_clr = 0; s_en = 1; s_down = 1;
      @(negedge clk); chk("sat_borrow", 32'(s_bw), 0);
      @(posedge clk); #1; chk("sat_hold0", 32'(s_cnt), 0);
      s_down = 0; s_ld = 1; s_in = 5'd23;
      @(posedge clk); #1; chk("sat_load", 32'(s_cnt), 23);
      s_ld = 0; s_up = 1;
      @(negedge clk); chk("sat_carry", 32'(s_cy), 0);
      @(posedge clk); #1; chk("sat_hold23", 32'(s_cnt), 23);
      s_up = 0; s_ld = 1; s_in = 5'd30;
      @(posedge clk); #1;
      chk("sat_clamp", 32'(s_cnt), 23);
      chk("sat_lderr", 32'(s_err), 1);
      $display("sat: count=%0d ld_err=%0d", s_cnt, s_err);
      s_ld = 0; s_en = 0;

      // cascade 23:59:58 -> 23:59:59 -> 00:00:00
      c_clr = 0; c_en = 1; c_ld = 1; c_hr_in = 5'd23; c_min_in = 6'd59; c_sec_in = 6'd58;
      @(posedge clk); #1;
      chk("casc_load", {hr_cnt, min_cnt, sec_cnt}, {5'd23, 6'd59, 6'd58});
      c_ld = 0; c_up = 1;
      @(negedge clk); chk("casc_sec_cy0", 32'(sec_cy), 0);
      @(posedge clk); #1;
      chk("casc_step1", {hr_cnt, min_cnt, sec_cnt}, {5'd23, 6'd59, 6'd59});
      @(negedge clk);
      chk("casc_cy", {sec_cy, min_cy, hr_cy}, 3'b111);
      @(posedge clk); #1;
      chk("casc_step2", {hr_cnt, min_cnt, sec_cnt}, 0);
      $display("cascade: %0d:%0d:%0d", hr_cnt, min_cnt, sec_cnt);
      c_up = 0; c_en = 0;

      // one-bit counter toggles on every Up edge
      w_clr = 0; w_en = 1; w_up = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("w1_carry", 32'(w_cy), (k % 2 == 1) ? 1 : 0);
         @(posedge clk); #1;
         chk("w1_count", 32'(w_cnt), (k + 1) % 2);
         $display("w1 %0d: count=%0d", k, w_cnt);
      end
      w_up = 0; w_en = 0;

      // randomized traffic on the wrapping and saturating instances
      m_model = 0;
      s_model = 23;
      for (int n = 0; n < 200; n++) begin
         m_clr  = ($urandom_range(15) == 0);
         m_en   = ($urandom_range(3) != 0);
         m_ld   = ($urandom_range(7) == 0);
         m_in   = 6'($urandom_range(63));
         m_up   = 1'($urandom_range(1));
         m_down = 1'($urandom_range(1));
         s_clr  = ($urandom_range(15) == 0);
         s_en   = ($urandom_range(3) != 0);
         s_ld   = ($urandom_range(7) == 0);
         s_in   = 5'($urandom_range(31));
         s_up   = 1'($urandom_range(1));
         s_down = 1'($urandom_range(1));
         ref_next(59, 0, m_model, int'(m_clr), int'(m_en), int'(m_ld), int'(m_in),
                  int'(m_up), int'(m_down), nx, ne, ncy, nbw);
         ref_next(23, 1, s_model, int'(s_clr), int'(s_en), int'(s_ld), int'(s_in),
                  int'(s_up), int'(s_down), sx, se, scy, sbw);
         @(negedge clk);
         chk("rnd_carry", 32'(m_cy), ncy);
         chk("rnd_borrow", 32'(m_bw), nbw);
         chk("rnd_sat_cybw", {s_cy, s_bw}, {scy[0], sbw[0]});
         @(posedge clk); #1;
         chk("rnd_count", 32'(m_cnt), nx);
         chk("rnd_lderr", 32'(m_err), ne);
         chk("rnd_sat_count", 32'(s_cnt), sx);
         chk("rnd_sat_lderr", 32'(s_err), se);
         $display("rnd %0d: count=%0d/%0d sat=%0d/%0d", n, m_cnt, nx, s_cnt, sx);
         m_model = nx;
         s_model = sx;
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
